// File: rtl/ahb_regslave.sv
// AHB-Lite register slave: six config registers (REG0-REG5), a live status
// word (REG6) and a doorbell interrupt bit (REG7). Unaligned, oversized or
// out-of-window accesses get a two-cycle ERROR response.
// Optional feature macro: AHBSLV_WAIT_EN. When it is defined, every OKAY
// transfer is stretched by WAIT_CYCLES wait states. Otherwise OKAY transfers
// complete with zero wait states and WAIT_CYCLES has no effect.
module ahb_regslave #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           HSEL,
   input  logic [31:0]    HADDR,
   input  logic [1:0]     HTRANS,
   input  logic           HWRITE,
   input  logic [2:0]     HSIZE,
   input  logic [31:0]    HWDATA,
   input  logic           HREADY,
   output logic           HREADYOUT,
   output logic [31:0]    HRDATA,
   output logic           HRESP,
   input  logic [31:0]    stat_i,
   output logic [191:0]   cfg_o,
   output logic           irq_o
);

`ifdef AHBSLV_WAIT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ERR1 = 2'd2, ERR2 = 2'd3} state_t;
   logic [1:0] cnt_q, cnt_d;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ERR1 = 2'd2, ERR2 = 2'd3} state_t;
`endif

   state_t           state_q, state_d;
   logic             pend_q, pend_d;
   logic             wr_q, wr_d;
   logic [2:0]       idx_q, idx_d;
   logic [1:0]       size_q, size_d;
   logic [1:0]       lane_q, lane_d;
   logic [5:0][31:0] cfg_q, cfg_d;
   logic             irq_q, irq_d;
   logic             hreadyout_q, hreadyout_d;
   logic             hresp_q, hresp_d;

   logic             accept;
   logic             addr_err;
   logic             complete;
   logic [3:0]       be;
   logic [31:0]      rdata;

   // Address-phase decode and the byte-lane mask of the pending transfer.
   always_comb begin
      accept   = HSEL & HTRANS[1] & HREADY;
      addr_err = (|HADDR[11:5]) | (HSIZE > 3'd2) |
                 ((HSIZE == 3'd1) & HADDR[0]) |
                 ((HSIZE == 3'd2) & (|HADDR[1:0]));
      complete = (state_q == IDLE) & pend_q;
      case (size_q)
         2'd0:    be = 4'b0001 << lane_q;
         2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Next-state, capture of the address phase, register writes.
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q & ~complete;
      wr_d    = wr_q;
      idx_d   = idx_q;
      size_d  = size_q;
      lane_d  = lane_q;
      cfg_d   = cfg_q;
      irq_d   = irq_q;
`ifdef AHBSLV_WAIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            if (accept) begin
               wr_d   = HWRITE;
               idx_d  = HADDR[4:2];
               size_d = HSIZE[1:0];
               lane_d = HADDR[1:0];
               if (addr_err) begin
                  state_d = ERR1;
               end else begin
                  pend_d = 1'b1;
`ifdef AHBSLV_WAIT_EN
                  if (WAIT_CYCLES != 0) begin
                     state_d = WAIT;
                     cnt_d   = 2'(WAIT_CYCLES - 1);
                  end
`endif
               end
            end
         end
`ifdef AHBSLV_WAIT_EN
         WAIT: begin
            if (cnt_q == 2'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 2'd1;
         end
`endif
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase

      // REG6 is read-only status, so writes to it are silently dropped.
      if (complete && wr_q) begin
         if (idx_q == 3'd7) begin
            if (be[0]) irq_d = HWDATA[0];
         end else begin
            for (int r = 0; r < 6; r++) begin
               if (idx_q == 3'(r)) begin
                  for (int l = 0; l < 4; l++) begin
                     if (be[l]) cfg_d[r][8*l +: 8] = HWDATA[8*l +: 8];
                  end
               end
            end
         end
      end

      hreadyout_d = (state_d == IDLE) || (state_d == ERR2);
      hresp_d     = (state_d == ERR1) || (state_d == ERR2);
   end

   // Read data is only driven during the completing cycle of an OKAY read.
   always_comb begin
      rdata = '0;
      if (complete && !wr_q) begin
         if (idx_q == 3'd6)      rdata = stat_i;
         else if (idx_q == 3'd7) rdata = {31'b0, irq_q};
         else begin
            for (int r = 0; r < 6; r++) begin
               if (idx_q == 3'(r)) rdata = cfg_q[r];
            end
         end
      end
   end

   // State, transfer context, registers and bus response flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         pend_q      <= 1'b0;
         wr_q        <= 1'b0;
         idx_q       <= '0;
         size_q      <= '0;
         lane_q      <= '0;
         cfg_q       <= '0;
         irq_q       <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
`ifdef AHBSLV_WAIT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         wr_q        <= wr_d;
         idx_q       <= idx_d;
         size_q      <= size_d;
         lane_q      <= lane_d;
         cfg_q       <= cfg_d;
         irq_q       <= irq_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
`ifdef AHBSLV_WAIT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = rdata;
   assign cfg_o     = cfg_q;
   assign irq_o     = irq_q;

endmodule
